// File: rtl/pll_clkgen.sv
// pll_clkgen: supervises the PLL lock input, sequences a clean downstream
// reset, and generates NCH fractional clock-enable strobes from phase
// accumulators running on the PLL output clock.
// Optional build macro PLL_CLKGEN_LOSS_COUNT_EN adds the 16-bit saturating
// loss_count output, which counts RUN->LOST transitions.
module pll_clkgen #(
  parameter int NCH           = 2,
  parameter int ACC_W         = 24,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOSS_CYCLES   = 4
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic [NCH*ACC_W-1:0] inc,
  input  logic                 inc_load,
  output logic                 locked,
  output logic                 rst_out,
  output logic [NCH-1:0]       ce,
  output logic [2:0]           state
`ifdef PLL_CLKGEN_LOSS_COUNT_EN
  ,
  output logic [15:0]          loss_count
`endif
);

  localparam logic [2:0] ST_HOLD   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_LOST   = 3'd4;

  // Settle counter only has to reach SETTLE_CYCLES-1; loss counter reaches LOSS_CYCLES-1
  localparam int SCW = $clog2(SETTLE_CYCLES);
  localparam int LCW = $clog2(LOSS_CYCLES + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [LCW-1:0] LOSS_LAST   = LCW'(LOSS_CYCLES - 1);

  logic                          sync1_r;
  logic                          lk_r;
  logic [2:0]                    state_r;
  logic [2:0]                    next_state_s;
  logic [SCW-1:0]                settle_cnt_r;
  logic [LCW-1:0]                loss_cnt_r;
  logic                          run_hold_s;
  logic                          locked_r;
  logic                          rst_out_r;
  logic [NCH-1:0][ACC_W-1:0]     incr_r;
  logic [NCH-1:0][ACC_W-1:0]     acc_r;
  logic [NCH-1:0][ACC_W:0]       sum_s;
  logic [NCH-1:0]                ce_r;

  // Two-flop synchroniser bringing the asynchronous PLL lock into clkin
  always_ff @(posedge clkin) begin
    if (rst) begin
      sync1_r <= 1'b0;
      lk_r    <= 1'b0;
    end else begin
      sync1_r <= pll_locked;
      lk_r    <= sync1_r;
    end
  end

  // FSM state register
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_HOLD: begin
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (lk_r) begin
          next_state_s = ST_SETTLE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_SETTLE: begin
        // A lock drop in the final settle cycle still sends us back to WAIT
        if (!lk_r) begin
          next_state_s = ST_WAIT;
        end else if (settle_cnt_r == SETTLE_LAST) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_SETTLE;
        end
      end
      ST_RUN: begin
        if (!lk_r && (loss_cnt_r == LOSS_LAST)) begin
          next_state_s = ST_LOST;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_LOST: begin
        next_state_s = ST_WAIT;
      end
      default: begin
        next_state_s = ST_HOLD;
      end
    endcase
  end

  // FSM output decode: released only while RUN is held across the coming edge,
  // so leaving RUN reasserts reset on the same edge the FSM enters LOST
  always_comb begin
    run_hold_s = 1'b0;
    if ((state_r == ST_RUN) && (next_state_s == ST_RUN)) begin
      run_hold_s = 1'b1;
    end else begin
      run_hold_s = 1'b0;
    end
  end

  // Registered lock status and downstream reset
  always_ff @(posedge clkin) begin
    if (rst) begin
      locked_r  <= 1'b0;
      rst_out_r <= 1'b1;
    end else begin
      locked_r  <= run_hold_s;
      rst_out_r <= ~run_hold_s;
    end
  end

  // Settle counter: counts consecutive locked cycles while settling
  always_ff @(posedge clkin) begin
    if (rst) begin
      settle_cnt_r <= '0;
    end else if ((state_r == ST_SETTLE) && lk_r) begin
      settle_cnt_r <= settle_cnt_r + SCW'(1);
    end else begin
      settle_cnt_r <= '0;
    end
  end

  // Loss counter: counts consecutive unlocked cycles while running
  always_ff @(posedge clkin) begin
    if (rst) begin
      loss_cnt_r <= '0;
    end else if ((state_r == ST_RUN) && !lk_r) begin
      loss_cnt_r <= loss_cnt_r + LCW'(1);
    end else begin
      loss_cnt_r <= '0;
    end
  end

  // Increment registers: loadable in any state, cleared only by rst
  always_ff @(posedge clkin) begin
    if (rst) begin
      incr_r <= '0;
    end else if (inc_load) begin
      incr_r <= inc;
    end else begin
      incr_r <= incr_r;
    end
  end

  // Per-channel accumulator sum with carry-out in the top bit
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < NCH; k++) begin
      sum_s[k] = {1'b0, acc_r[k]} + {1'b0, incr_r[k]};
    end
  end

  // Phase accumulators and strobes; held at zero outside RUN so that every
  // channel restarts phase-aligned on RUN entry
  always_ff @(posedge clkin) begin
    if (rst) begin
      acc_r <= '0;
      ce_r  <= '0;
    end else if (run_hold_s) begin
      for (int k = 0; k < NCH; k++) begin
        acc_r[k] <= sum_s[k][ACC_W-1:0];
        ce_r[k]  <= sum_s[k][ACC_W];
      end
    end else begin
      acc_r <= '0;
      ce_r  <= '0;
    end
  end

`ifdef PLL_CLKGEN_LOSS_COUNT_EN
  logic [15:0] loss_count_r;

  // Saturating count of RUN->LOST transitions, cleared only by rst
  always_ff @(posedge clkin) begin
    if (rst) begin
      loss_count_r <= 16'd0;
    end else if ((state_r == ST_RUN) && (next_state_s == ST_LOST) &&
                 (loss_count_r != 16'hFFFF)) begin
      loss_count_r <= loss_count_r + 16'd1;
    end else begin
      loss_count_r <= loss_count_r;
    end
  end

  assign loss_count = loss_count_r;
`else
  // Lock-loss counting is not built in this configuration
`endif

  assign locked  = locked_r;
  assign rst_out = rst_out_r;
  assign ce      = ce_r;
  assign state   = state_r;

endmodule

// File: tb/tb_pll_clkgen.sv
// tb_pll_clkgen: directed lock/reset sequencing plus randomized increment
// loads, checked against a turn-counting model of the fractional strobes.
module tb_pll_clkgen;

  localparam int NCH    = 2;
  localparam int ACC_W  = 8;
  localparam int SETTLE = 16;
  localparam int LOSS   = 4;
  localparam longint MODV = 256;

  logic        clkin;
  logic        rst;
  logic        pll_locked;
  logic [15:0] inc;
  logic        inc_load;
  logic        locked;
  logic        rst_out;
  logic [1:0]  ce;
  logic [2:0]  state;
`ifdef PLL_CLKGEN_LOSS_COUNT_EN
  logic [15:0] loss_count;
`endif

  int     n_checks;
  int     n_fail;
  longint phase_m [2];
  longint incr_m [2];

  pll_clkgen #(
    .NCH(NCH), .ACC_W(ACC_W), .SETTLE_CYCLES(SETTLE), .LOSS_CYCLES(LOSS)
  ) dut (
    .clkin(clkin),
    .rst(rst),
    .pll_locked(pll_locked),
    .inc(inc),
    .inc_load(inc_load),
    .locked(locked),
    .rst_out(rst_out),
    .ce(ce),
    .state(state)
`ifdef PLL_CLKGEN_LOSS_COUNT_EN
    ,
    .loss_count(loss_count)
`endif
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe count of one add = number of whole turns completed by the phase
  task automatic model_add(output logic [1:0] exp_ce);
    for (int k = 0; k < 2; k++) begin
      exp_ce[k] = (((phase_m[k] + incr_m[k]) / MODV) != (phase_m[k] / MODV));
      phase_m[k] = phase_m[k] + incr_m[k];
    end
  endtask

  function automatic logic [7:0] rnd_inc();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'd0;
    else if (r == 1) return 8'd255;
    else return 8'($urandom_range(1, 254));
  endfunction

  // One cycle in RUN: optional load (new value used from the next add)
  task automatic run_cycle(input string tag, input bit ld, input logic [7:0] n0, input logic [7:0] n1);
    logic [1:0] e;
    inc_load = ld;
    if (ld) inc = {n1, n0};
    tick();
    model_add(e);
    if (ld) begin
      incr_m[0] = longint'(n0);
      incr_m[1] = longint'(n1);
    end
    inc_load = 1'b0;
    chk({tag, " ce"}, 32'(ce), 32'(e));
    chk({tag, " locked"}, 32'(locked), 32'd1);
  endtask

  // Count cycles until the downstream reset releases; first add happens on that edge
  task automatic wait_release(input string tag, input int exp_n);
    int n;
    logic [1:0] e;
    n = 0;
    do begin
      tick();
      inc_load = 1'b0;
      n++;
    end while ((rst_out !== 1'b0) && (n < 80));
    chk({tag, " release cycles"}, 32'(n), 32'(exp_n));
    chk({tag, " locked"}, 32'(locked), 32'd1);
    chk({tag, " state"}, 32'(state), 32'd3);
    phase_m[0] = 0;
    phase_m[1] = 0;
    model_add(e);
    chk({tag, " first ce"}, 32'(ce), 32'(e));
  endtask

  initial begin
    int cnt0;
    int cnt1;
    int first1;
    int glen;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    pll_locked = 1'b1;
    inc        = 16'd0;
    inc_load   = 1'b0;
    phase_m[0] = 0; phase_m[1] = 0;
    incr_m[0]  = 0; incr_m[1]  = 0;

    repeat (3) tick();
    chk("reset locked", 32'(locked), 32'd0);
    chk("reset rst_out", 32'(rst_out), 32'd1);
    chk("reset ce", 32'(ce), 32'd0);
    chk("reset state", 32'(state), 32'd0);
`ifdef PLL_CLKGEN_LOSS_COUNT_EN
    chk("reset loss_count", 32'(loss_count), 32'd0);
`endif

    // Boot: load 64/96 while in HOLD; release 2+1+16+1 cycles after rst drops
    rst      = 1'b0;
    inc      = {8'd96, 8'd64};
    inc_load = 1'b1;
    incr_m[0] = 64;
    incr_m[1] = 96;
    wait_release("boot", 20);

    // Directed rate check over 16 cycles
    cnt0 = 0; cnt1 = 0; first1 = -1;
    for (int i = 1; i <= 16; i++) begin
      run_cycle("rate", 1'b0, 8'd0, 8'd0);
      if (ce[0] === 1'b1) cnt0++;
      if (ce[1] === 1'b1) begin
        cnt1++;
        if (first1 < 0) first1 = i;
      end
    end
    chk("rate ce0 count", 32'(cnt0), 32'd4);
    chk("rate ce1 count", 32'(cnt1), 32'd6);
    chk("rate ce1 first", 32'(first1), 32'd2);

    // Increment change 64->128 coincident with a ch0 carry
    run_cycle("pre", 1'b0, 8'd0, 8'd0);
    run_cycle("pre", 1'b0, 8'd0, 8'd0);
    run_cycle("load", 1'b1, 8'd128, 8'd96);
    chk("coincident ce0", 32'(ce[0]), 32'd1);
    cnt0 = 0;
    for (int i = 1; i <= 8; i++) begin
      run_cycle("p2", 1'b0, 8'd0, 8'd0);
      if (ce[0] === 1'b1) cnt0++;
    end
    chk("period2 ce0 count", 32'(cnt0), 32'd4);

    // Randomized increments and load timing
    for (int i = 0; i < 48; i++) begin
      run_cycle("rnd", ($urandom_range(0, 7) == 0), rnd_inc(), rnd_inc());
    end

    // Lock glitches shorter than LOSS cycles are ignored
    for (int g = 0; g < 3; g++) begin
      glen = (g == 0) ? 3 : int'($urandom_range(1, 3));
      pll_locked = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        run_cycle("glitch", ($urandom_range(0, 5) == 0), rnd_inc(), rnd_inc());
        if (i == glen) pll_locked = 1'b1;
      end
    end

    // Four-cycle loss: LOST then WAIT
    pll_locked = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      run_cycle("preloss", 1'b0, 8'd0, 8'd0);
      if (i == 4) pll_locked = 1'b1;
    end
    tick();
    chk("loss state", 32'(state), 32'd4);
    chk("loss rst_out", 32'(rst_out), 32'd1);
    chk("loss locked", 32'(locked), 32'd0);
    chk("loss ce", 32'(ce), 32'd0);
`ifdef PLL_CLKGEN_LOSS_COUNT_EN
    chk("loss_count", 32'(loss_count), 32'd1);
`endif
    tick();
    chk("after lost state", 32'(state), 32'd1);
    // Relock, but drop lock once when the settle count is at 10
    repeat (9) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    chk("settle state", 32'(state), 32'd2);
    tick();
    chk("settle abort state", 32'(state), 32'd1);
    chk("settle abort rst_out", 32'(rst_out), 32'd1);
    tick();
    chk("resettle state", 32'(state), 32'd2);
    wait_release("relock", 17);
`ifdef PLL_CLKGEN_LOSS_COUNT_EN
    chk("relock loss_count", 32'(loss_count), 32'd1);
`endif
    for (int i = 0; i < 12; i++) begin
      run_cycle("rnd2", ($urandom_range(0, 3) == 0), rnd_inc(), rnd_inc());
    end

    // Reset in the middle of RUN with strobes active
    run_cycle("fast", 1'b1, 8'd250, 8'd255);
    run_cycle("fast", 1'b0, 8'd0, 8'd0);
    run_cycle("fast", 1'b0, 8'd0, 8'd0);
    chk("fast ce1 active", 32'(ce[1]), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst ce", 32'(ce), 32'd0);
    chk("midrst rst_out", 32'(rst_out), 32'd1);
    chk("midrst locked", 32'(locked), 32'd0);
    chk("midrst state", 32'(state), 32'd0);
`ifdef PLL_CLKGEN_LOSS_COUNT_EN
    chk("midrst loss_count", 32'(loss_count), 32'd0);
`endif
    rst = 1'b0;
    incr_m[0] = 0;
    incr_m[1] = 0;
    wait_release("reboot", 20);
    for (int i = 0; i < 16; i++) begin
      run_cycle("zeroinc", 1'b0, 8'd0, 8'd0);
    end
    run_cycle("newinc", 1'b1, rnd_inc(), rnd_inc());
    for (int i = 0; i < 16; i++) begin
      run_cycle("newinc", 1'b0, 8'd0, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_clkgen.md
Name: pll_clkgen

Overview:
Parametrised successor to the single-output PLL wrapper. Supervises the PLL lock signal and sequences a clean system reset. Generates NCH independent fractional clock-enable strobes from the PLL output clock using phase accumulators, e.g. 48 kHz and 44.1 kHz DAC sample strobes from 76.8 MHz. Sits directly after the PLL, clocked by its output; feeds the DAC datapath.

Parameters:
NCH, 2, number of clock-enable channels (1..8)
ACC_W, 24, phase accumulator width in bits (8..32)
SETTLE_CYCLES, 1024, consecutive synchronised-lock cycles required before reset release (>=2)
LOSS_CYCLES, 4, consecutive unlocked cycles required to declare lock loss (>=1)

Ports:
clkin  in  1  system clock (PLL output clock)
rst  in  1  synchronous, active-high reset
pll_locked  in  1  raw PLL LOCK, asynchronous to clkin
inc  in  NCH*ACC_W  per-channel phase increment; channel k uses bits [k*ACC_W +: ACC_W]
inc_load  in  1  one-cycle strobe; loads all increments from inc
locked  out  1  debounced lock status
rst_out  out  1  synchronous active-high reset for downstream logic
ce  out  NCH  per-channel one-cycle clock-enable strobes
state  out  3  FSM state encoding, for debug

Behaviour:
- Reset (rst=1, sampled on clkin): FSM goes to HOLD. Sync flops, counters, accumulators and increment registers clear to 0. Reset values: locked=0, rst_out=1, ce=0, state=HOLD.
- pll_locked passes through a 2-flop synchroniser; lk denotes the synchronised value. Total latency is 2 cycles.
- FSM encodings: HOLD=0, WAIT=1, SETTLE=2, RUN=3, LOST=4.
  - HOLD: one cycle after rst deasserts, go to WAIT.
  - WAIT: if lk=1, go to SETTLE and clear the settle counter.
  - SETTLE: the counter increments each cycle while lk=1. If lk=0, return to WAIT. When the counter reaches SETTLE_CYCLES-1 with lk=1, go to RUN.
  - RUN: the loss counter counts consecutive lk=0 cycles and clears whenever lk=1. When it reaches LOSS_CYCLES, go to LOST. Glitches shorter than LOSS_CYCLES are ignored.
  - LOST: one cycle, then go to WAIT.
- Outputs versus state:
  - locked=1 only in RUN.
  - rst_out=0 only in RUN. rst_out reasserts in the same cycle the FSM enters LOST.
  - All outputs are registered from the FSM state.
- Increments:
  - inc_load=1 captures inc into the increment registers on that edge. The new value takes effect in the following cycle's accumulation.
  - inc_load is accepted in any state. Increment registers are cleared only by rst.
- Accumulators:
  - In RUN only, each cycle acc[k] <= acc[k] + incr[k], modulo 2^ACC_W.
  - ce[k] is registered: it equals the carry-out of that addition, one cycle after the add.
  - ce[k] is never high for two consecutive cycles unless incr[k] >= 2^(ACC_W-1).
  - Outside RUN, accumulators hold 0 and ce=0. Accumulators are also cleared on entry to RUN, so all channels start phase-aligned.
- Strobe rate: f_ce = f_clkin * incr / 2^ACC_W.
  - incr=0 never strobes.
  - incr=2^ACC_W-1 strobes on every cycle except one per 2^ACC_W cycles.
- Simultaneous events:
  - rst overrides everything.
  - inc_load in the cycle a carry occurs: the carry uses the old increment.
  - lk falling in the last SETTLE cycle: return to WAIT, not RUN.

Optional Feature:
PLL_CLKGEN_LOSS_COUNT_EN
- Defined:
  - Adds output port loss_count (16 bits). It increments by 1 on every RUN->LOST transition and saturates at 16'hFFFF.
  - Cleared only by rst.
  - It is readable in every state.
- Undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then pll_locked=1 constant, SETTLE_CYCLES=16 -> rst_out=1 and locked=0 until exactly 2+1+16+1 cycles after reset release (sync, HOLD, settle, registered output); then rst_out=0 and locked=1.
- In SETTLE, drop pll_locked for 1 cycle at settle count 10 -> FSM returns to WAIT. The settle count restarts. Release is delayed by the full 16 cycles after relock.
- In RUN with LOSS_CYCLES=4, 3-cycle pll_locked low glitch -> locked stays 1. 4-cycle low -> rst_out=1 and state=LOST, then WAIT. With the macro defined, loss_count=1.
- ACC_W=8, incr[0]=64, incr[1]=96 -> ce[0] every 4 cycles exactly. ce[1] fires 3 times per 8 cycles, first strobe 3 cycles after RUN entry.
- Pulse inc_load in RUN changing incr[0] 64->128 -> the next cycle accumulates 128; ce[0] period becomes 2. An inc_load coincident with a carry still produces that ce.
- Assert rst mid-RUN with ce active -> next cycle: ce=0, rst_out=1, locked=0, state=HOLD. Increments clear, so ce stays 0 after relock until a new inc_load.
